// File: rtl/paddle_inputs.sv
// N-channel player input front end: per-input debounce, X1 quadrature detent
// decode and saturating paddle position tracking with bitmap output.
module paddle_inputs #(
  parameter int CHANNELS     = 2,
  parameter int DEBOUNCE_LEN = 16,
  parameter int FIELD        = 32,
  parameter int PADDLE_LEN   = 3,
  localparam int POSW        = $clog2(FIELD)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      enc_a,
  input  logic [CHANNELS-1:0]      enc_b,
  input  logic [CHANNELS-1:0]      invert,
  input  logic                     recenter,
  output logic [CHANNELS*POSW-1:0] pos_o,
  output logic [CHANNELS*FIELD-1:0] paddle_o,
  output logic [CHANNELS-1:0]      moved_o
);

  localparam logic [POSW-1:0] CENTRE  = POSW'((FIELD - PADDLE_LEN) / 2);
  localparam logic [POSW-1:0] MAX_POS = POSW'(FIELD - PADDLE_LEN);
  localparam int unsigned     PLEN    = PADDLE_LEN;

  // Only DEBOUNCE_LEN-1 past samples are stored; the live sample completes the window.
  logic [DEBOUNCE_LEN-2:0] hist_a [CHANNELS];
  logic [DEBOUNCE_LEN-2:0] hist_b [CHANNELS];
  logic [DEBOUNCE_LEN-1:0] sh_a   [CHANNELS];
  logic [DEBOUNCE_LEN-1:0] sh_b   [CHANNELS];
  logic [POSW-1:0]         pos    [CHANNELS];
  logic [CHANNELS-1:0]     deb_a, deb_b, a_prev, moved;
  logic [CHANNELS-1:0]     detent, down;

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sh_a[i]   = {hist_a[i], enc_a[i]};
      sh_b[i]   = {hist_b[i], enc_b[i]};
      detent[i] = deb_a[i] & ~a_prev[i];
      down[i]   = deb_b[i] ^ invert[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hist_a[i] <= '0;
        hist_b[i] <= '0;
        pos[i]    <= CENTRE;
      end
      deb_a  <= '0;
      deb_b  <= '0;
      a_prev <= '0;
      moved  <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hist_a[i] <= sh_a[i][DEBOUNCE_LEN-2:0];
        hist_b[i] <= sh_b[i][DEBOUNCE_LEN-2:0];
        if (&sh_a[i])       deb_a[i] <= 1'b1;
        else if (~|sh_a[i]) deb_a[i] <= 1'b0;
        if (&sh_b[i])       deb_b[i] <= 1'b1;
        else if (~|sh_b[i]) deb_b[i] <= 1'b0;
        a_prev[i] <= deb_a[i];
        moved[i]  <= 1'b0;
        // Recenter discards a pending detent rather than deferring it.
        if (recenter) begin
          pos[i] <= CENTRE;
        end else if (detent[i]) begin
          if (down[i]) begin
            if (pos[i] != '0) begin
              pos[i]   <= pos[i] - 1'b1;
              moved[i] <= 1'b1;
            end
          end else if (pos[i] != MAX_POS) begin
            pos[i]   <= pos[i] + 1'b1;
            moved[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    pos_o    = '0;
    paddle_o = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pos_o[i*POSW +: POSW] = pos[i];
      for (int unsigned j = 0; j < FIELD; j++) begin
        paddle_o[i*FIELD + j] = (j >= 32'(pos[i])) && (j < 32'(pos[i]) + PLEN);
      end
    end
  end

  assign moved_o = moved;

endmodule
